// File: rtl/nn_output_framer.sv
// Frames the HLS result stream into AXI-stream packets of a programmable length,
// attaching the tuser header captured from the matching input packet.
module nn_output_framer #(
    parameter int unsigned SR_OUT_LEN    = 130,
    parameter int unsigned HDR_FIFO_SIZE = 3,
    parameter int unsigned DWIDTH        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_stb,
    input  logic [7:0]        set_addr,
    input  logic [31:0]       set_data,
    input  logic [127:0]      hdr_tuser,
    input  logic              hdr_valid,
    input  logic [DWIDTH-1:0] res_din,
    input  logic              res_write,
    output logic              res_full_n,
    output logic [DWIDTH-1:0] o_tdata,
    output logic [127:0]      o_tuser,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic [15:0]       pkt_len,
    output logic [31:0]       pkt_count,
    output logic              hdr_overflow
);

    localparam int unsigned Depth = 1 << HDR_FIFO_SIZE;
    localparam logic [7:0] LenAddr = 8'(SR_OUT_LEN);
    localparam logic [HDR_FIFO_SIZE:0] FillZero = '0;
    localparam logic [HDR_FIFO_SIZE:0] FillOne = (HDR_FIFO_SIZE + 1)'(1);
    localparam logic [HDR_FIFO_SIZE:0] FillFull = (HDR_FIFO_SIZE + 1)'(Depth);
    localparam logic [HDR_FIFO_SIZE-1:0] PtrOne = (HDR_FIFO_SIZE)'(1);

    typedef enum logic [0:0] {StIdle, StPayload} state_e;

    state_e              state_q;
    logic [DWIDTH-1:0]   tdata_q;
    logic [127:0]        tuser_q;
    logic                tlast_q;
    logic                tvalid_q;
    logic [15:0]         len_q;
    logic [15:0]         pkt_len_q;
    logic [15:0]         cnt_q;
    logic [31:0]         pkt_count_q;

    logic [127:0]           mem_q [Depth];
    logic [HDR_FIFO_SIZE-1:0] wr_ptr_q;
    logic [HDR_FIFO_SIZE-1:0] rd_ptr_q;
    logic [HDR_FIFO_SIZE-1:0] rd_ptr_next;
    logic [HDR_FIFO_SIZE:0]   fill_q;
    logic                     overflow_q;

    logic         out_hs_last;
    logic         pop;
    logic         push_ok;
    logic         hdr_avail;
    logic [127:0] head;
    logic         can_accept;
    logic         accept;
    logic         first_last;
    logic [15:0]  cnt_inc;
    logic         pay_last;
    logic         unused_set_data;

    assign unused_set_data = ^set_data[31:16];

    assign out_hs_last = tvalid_q & o_tready & tlast_q;
    assign pop         = out_hs_last & (fill_q != FillZero);
    assign push_ok     = hdr_valid & ((fill_q != FillFull) | pop);
    assign rd_ptr_next = rd_ptr_q + PtrOne;

    // The closing beat of the previous packet may pop this very cycle; look past it.
    assign hdr_avail = pop ? (fill_q > FillOne) : (fill_q != FillZero);
    assign head      = pop ? mem_q[rd_ptr_next] : mem_q[rd_ptr_q];

    assign can_accept = (~tvalid_q | o_tready) & ((state_q == StPayload) | hdr_avail) & ~reset;
    assign res_full_n = can_accept;
    assign accept     = res_write & can_accept;

    assign first_last = (len_q == 16'd1);
    assign cnt_inc    = cnt_q + 16'd1;
    assign pay_last   = (cnt_inc == pkt_len_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop) rd_ptr_q <= rd_ptr_next;
            if (push_ok && !pop) begin
                fill_q <= fill_q + FillOne;
            end else if (!push_ok && pop) begin
                fill_q <= fill_q - FillOne;
            end
            if (hdr_valid && !push_ok) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= hdr_tuser;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            tdata_q     <= '0;
            tuser_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            len_q       <= 16'd1;
            pkt_len_q   <= 16'd1;
            cnt_q       <= '0;
            pkt_count_q <= '0;
        end else begin
            if (set_stb && set_addr == LenAddr) begin
                len_q <= (set_data[15:0] == 16'd0) ? 16'd1 : set_data[15:0];
            end
            if (out_hs_last) pkt_count_q <= pkt_count_q + 32'd1;

            if (accept) begin
                tdata_q  <= res_din;
                tvalid_q <= 1'b1;
                unique case (state_q)
                    StIdle: begin
                        tuser_q   <= head;
                        pkt_len_q <= len_q;
                        cnt_q     <= 16'd1;
                        tlast_q   <= first_last;
                        state_q   <= first_last ? StIdle : StPayload;
                    end
                    StPayload: begin
                        cnt_q   <= cnt_inc;
                        tlast_q <= pay_last;
                        state_q <= pay_last ? StIdle : StPayload;
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (o_tready) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
        end
    end

    assign o_tdata      = tdata_q;
    assign o_tuser      = tuser_q;
    assign o_tlast      = tlast_q;
    assign o_tvalid     = tvalid_q;
    assign pkt_len      = pkt_len_q;
    assign pkt_count    = pkt_count_q;
    assign hdr_overflow = overflow_q;

endmodule

// File: tb/tb_nn_output_framer.sv
// Directed bench for nn_output_framer: framing, header tagging, backpressure,
// length updates, header overflow and mid-packet reset.
module tb_nn_output_framer;

    typedef struct packed {
        logic [15:0]  d;
        logic         l;
        logic [127:0] u;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         set_stb;
    logic [7:0]   set_addr;
    logic [31:0]  set_data;
    logic [127:0] hdr_tuser;
    logic         hdr_valid;
    logic [15:0]  res_din;
    logic         res_write;
    logic         res_full_n;
    logic [15:0]  o_tdata;
    logic [127:0] o_tuser;
    logic         o_tlast;
    logic         o_tvalid;
    logic         o_tready;
    logic [15:0]  pkt_len;
    logic [31:0]  pkt_count;
    logic         hdr_overflow;

    int    checks = 0;
    int    failures = 0;
    int    timeouts = 0;
    int    wait_cycles = 0;
    int    rf_err = 0;
    int    stall_err = 0;
    int    base;
    logic  tog_en = 1'b0;
    logic [1:0] tog_cnt = 2'd0;
    logic [3:0] tog_pat = 4'b1001;
    logic  prev_stall = 1'b0;
    beat_t prev_beat;
    beat_t beats[$];

    nn_output_framer dut (
        .clk          (clk),
        .reset        (reset),
        .set_stb      (set_stb),
        .set_addr     (set_addr),
        .set_data     (set_data),
        .hdr_tuser    (hdr_tuser),
        .hdr_valid    (hdr_valid),
        .res_din      (res_din),
        .res_write    (res_write),
        .res_full_n   (res_full_n),
        .o_tdata      (o_tdata),
        .o_tuser      (o_tuser),
        .o_tlast      (o_tlast),
        .o_tvalid     (o_tvalid),
        .o_tready     (o_tready),
        .pkt_len      (pkt_len),
        .pkt_count    (pkt_count),
        .hdr_overflow (hdr_overflow)
    );

    always #5 clk = ~clk;

    // Ready pattern 1,0,0,1 when toggling is enabled; otherwise held high.
    always @(posedge clk) tog_cnt <= tog_en ? tog_cnt + 2'd1 : 2'd0;
    assign o_tready = tog_en ? tog_pat[tog_cnt] : 1'b1;

    always @(negedge clk) begin
        if (o_tvalid && o_tready) beats.push_back({o_tdata, o_tlast, o_tuser});
        if (o_tvalid && !o_tready && res_full_n) rf_err++;
        if (prev_stall && (!o_tvalid || {o_tdata, o_tlast, o_tuser} !== prev_beat)) stall_err++;
        prev_stall = o_tvalid && !o_tready;
        prev_beat  = {o_tdata, o_tlast, o_tuser};
    end

    function automatic logic [127:0] hdr(input logic [7:0] k);
        return {4{24'hC0DE00, k}};
    endfunction

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [15:0] d,
                              input logic l, input logic [127:0] u);
        if (idx < beats.size()) begin
            check(tag, {15'd0, beats[idx]}, {15'd0, d, l, u});
        end else begin
            checks++;
            failures++;
            $error("FAIL %s: beat %0d observed none expected data %0h", tag, idx, d);
        end
    endtask

    task automatic set_len(input logic [31:0] v);
        @(posedge clk); #1;
        set_stb = 1'b1; set_addr = 8'd130; set_data = v;
        @(posedge clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic push(input logic [127:0] h);
        @(posedge clk); #1;
        hdr_valid = 1'b1; hdr_tuser = h;
        @(posedge clk); #1;
        hdr_valid = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [15:0] d);
        int n = 0;
        res_din = d;
        res_write = 1'b1;
        @(negedge clk);
        while (!res_full_n && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!res_full_n) timeouts++;
        wait_cycles += n;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
        hdr_tuser = '0; hdr_valid = 1'b0; res_din = '0; res_write = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_full_n", 160'(res_full_n), 160'(0));
        check("rst_tvalid", 160'(o_tvalid), 160'(0));
        check("rst_tlast", 160'(o_tlast), 160'(0));
        check("rst_tdata", 160'(o_tdata), 160'(0));
        check("rst_tuser", 160'(o_tuser), 160'(0));
        check("rst_pkt_len", 160'(pkt_len), 160'(1));
        check("rst_pkt_count", 160'(pkt_count), 160'(0));
        check("rst_overflow", 160'(hdr_overflow), 160'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Two packets of 4 at full rate.
        set_len(4);
        push(hdr(8'hA));
        push(hdr(8'hB));
        base = beats.size();
        wait_cycles = 0;
        for (int i = 0; i < 8; i++) send(16'(i));
        res_write = 1'b0;
        check("t1_no_stall", 160'(wait_cycles), 160'(0));
        idle(6);
        check("t1_count", 160'(beats.size() - base), 160'(8));
        for (int i = 0; i < 8; i++)
            check_beat("t1_beat", base + i, 16'(i), (i % 4) == 3, hdr(i < 4 ? 8'hA : 8'hB));
        check("t1_pkt_count", 160'(pkt_count), 160'(2));
        check("t1_pkt_len", 160'(pkt_len), 160'(4));

        // Same traffic with downstream stalls.
        push(hdr(8'hA));
        push(hdr(8'hB));
        base = beats.size();
        tog_en = 1'b1;
        for (int i = 0; i < 8; i++) send(16'h10 + 16'(i));
        res_write = 1'b0;
        idle(12);
        tog_en = 1'b0;
        idle(4);
        check("t2_count", 160'(beats.size() - base), 160'(8));
        for (int i = 0; i < 8; i++)
            check_beat("t2_beat", base + i, 16'h10 + 16'(i), (i % 4) == 3,
                       hdr(i < 4 ? 8'hA : 8'hB));
        check("t2_stall_stable", 160'(stall_err), 160'(0));
        check("t2_full_n_stall", 160'(rf_err), 160'(0));
        check("t2_pkt_count", 160'(pkt_count), 160'(4));

        // No header available: sample must wait for header C.
        set_len(1);
        base = beats.size();
        res_din = 16'h55; res_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_no_hdr", 160'(res_full_n), 160'(0));
        end
        @(posedge clk); #1;
        hdr_valid = 1'b1; hdr_tuser = hdr(8'hC);
        @(negedge clk);
        check("t3_push_cycle", 160'(res_full_n), 160'(0));
        @(posedge clk); #1;
        hdr_valid = 1'b0;
        @(negedge clk);
        check("t3_ready", 160'(res_full_n), 160'(1));
        @(posedge clk); #1;
        res_write = 1'b0;
        @(negedge clk);
        check("t3_out", {o_tvalid, o_tlast, o_tdata, o_tuser}, {1'b1, 1'b1, 16'h55, hdr(8'hC)});
        idle(3);
        check("t3_count", 160'(beats.size() - base), 160'(1));
        check("t3_pkt_count", 160'(pkt_count), 160'(5));

        // Length change mid-packet applies from the next packet.
        set_len(4);
        push(hdr(8'hD));
        push(hdr(8'hE));
        push(hdr(8'hF));
        base = beats.size();
        send(16'h40);
        send(16'h41);
        res_write = 1'b0;
        set_len(2);
        check("t4_len_first", 160'(pkt_len), 160'(4));
        for (int i = 2; i < 8; i++) send(16'h40 + 16'(i));
        res_write = 1'b0;
        idle(6);
        check("t4_count", 160'(beats.size() - base), 160'(8));
        for (int i = 0; i < 8; i++)
            check_beat("t4_beat", base + i, 16'h40 + 16'(i), i == 3 || i == 5 || i == 7,
                       hdr(i < 4 ? 8'hD : (i < 6 ? 8'hE : 8'hF)));
        check("t4_len_next", 160'(pkt_len), 160'(2));
        check("t4_pkt_count", 160'(pkt_count), 160'(8));

        // Nine headers into an 8-deep FIFO; length 0 means single-sample packets.
        set_len(0);
        @(posedge clk); #1;
        hdr_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            hdr_tuser = hdr(8'h80 + 8'(k));
            @(posedge clk); #1;
        end
        hdr_valid = 1'b0;
        check("t5_overflow", 160'(hdr_overflow), 160'(1));
        base = beats.size();
        for (int i = 0; i < 8; i++) send(16'h50 + 16'(i));
        res_write = 1'b0;
        check("t5_len_zero", 160'(pkt_len), 160'(1));
        idle(4);
        check("t5_count", 160'(beats.size() - base), 160'(8));
        for (int i = 0; i < 8; i++)
            check_beat("t5_beat", base + i, 16'h50 + 16'(i), 1'b1, hdr(8'h80 + 8'(i)));
        res_write = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_ninth_dropped", 160'(res_full_n), 160'(0));
        @(posedge clk); #1;
        res_write = 1'b0;
        check("t5_overflow_sticky", 160'(hdr_overflow), 160'(1));
        check("t5_pkt_count", 160'(pkt_count), 160'(16));

        // Reset in the middle of a packet.
        set_len(4);
        push(hdr(8'hE0));
        push(hdr(8'hE1));
        send(16'h60);
        send(16'h61);
        res_write = 1'b0;
        reset = 1'b1;
        #1;
        check("t6_rst_tvalid", 160'(o_tvalid), 160'(0));
        check("t6_rst_pkt_count", 160'(pkt_count), 160'(0));
        check("t6_rst_overflow", 160'(hdr_overflow), 160'(0));
        check("t6_rst_full_n", 160'(res_full_n), 160'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        set_len(4);
        push(hdr(8'hE2));
        base = beats.size();
        for (int i = 0; i < 4; i++) send(16'h70 + 16'(i));
        res_write = 1'b0;
        idle(4);
        check("t6_count", 160'(beats.size() - base), 160'(4));
        for (int i = 0; i < 4; i++)
            check_beat("t6_beat", base + i, 16'h70 + 16'(i), i == 3, hdr(8'hE2));
        check("t6_pkt_count", 160'(pkt_count), 160'(1));

        check("timeouts", 160'(timeouts), 160'(0));
        check("stall_stable_all", 160'(stall_err), 160'(0));
        check("full_n_stall_all", 160'(rf_err), 160'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
